fptd_iter_ctrl: RTL
===================

FPTD_ITER_CTRL -- requirements
Module: fptd_iter_ctrl

Interface
REQ-001 Parameter FRAME_LEN, default 104, number of Section instances (one per trellis stage) driven in parallel.
REQ-002 Parameter MAX_CYCLES, default 100, maximum decoding cycles (DCmax) per frame.
REQ-003 Parameter ET_WIN, default 2, consecutive zero-error cycles required for early termination.
REQ-004 Clock  input  1  single clock; all logic on rising edge.
REQ-005 nReset  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to decode the loaded frame.
REQ-007 abort  input  1  cancels the current decode.
REQ-008 b1_error_bus  input  FRAME_LEN  b1_error of every Section, bit i from section i.
REQ-009 Enable  output  1  broadcast Enable to all Sections.
REQ-010 nClear  output  1  broadcast active-low metric clear to all Sections.
REQ-011 busy  output  1  high from the CLEAR state through the DECODE state.
REQ-012 done  output  1  one-cycle pulse at frame completion.
REQ-013 converged  output  1  frame ended by early termination; held until next start.
REQ-014 cycle_count  output  $clog2(MAX_CYCLES+1)  decoding cycles used; held until next start.
REQ-015 err_count  output  $clog2(FRAME_LEN+1)  registered popcount of b1_error_bus.

Function
REQ-016 FSM states: IDLE, CLEAR, DECODE, DONE; all outputs registered.
REQ-017 IDLE: Enable=0, nClear=1, busy=0; start=1 -> CLEAR next cycle, clearing cycle_count, converged and the zero-run counter.
REQ-018 CLEAR lasts exactly one cycle: Enable=1, nClear=0 (Sections reset alpha/beta metrics); -> DECODE.
REQ-019 DECODE: Enable=1, nClear=1; cycle_count increments by 1 each DECODE cycle, saturating at MAX_CYCLES.
REQ-020 err_count updates each DECODE cycle from b1_error_bus, one-cycle latency; holds outside DECODE.
REQ-021 Zero-run counter increments when err_count==0 in DECODE, else resets to 0.
REQ-022 DECODE -> DONE when cycle_count reaches MAX_CYCLES, or (REQ-030) when zero-run reaches ET_WIN; the early-termination exit sets converged=1; if both happen in the same cycle, converged=1.
REQ-023 DONE lasts one cycle: done=1, Enable=0, nClear=1, busy=0; -> IDLE.
REQ-024 start outside IDLE is ignored; start during the DONE cycle is ignored.
REQ-025 abort in CLEAR or DECODE -> IDLE next cycle, Enable=0, no done pulse, converged=0; abort and start together in IDLE: abort wins, remain IDLE.
REQ-026 popcount width is exact; no overflow for FRAME_LEN all-ones (104 -> 7'd104).

Reset
REQ-027 nReset low asynchronously forces IDLE, Enable=0, nClear=1, busy=0, done=0, converged=0, cycle_count=0, err_count=0, and zero-run=0.
REQ-028 Reset asserted mid-decode aborts silently; the first start after release begins a fresh CLEAR.

Configuration
REQ-029 Macro FPTD_EARLY_TERM_EN selects early termination.
REQ-030 Defined: the ET_WIN zero-error exit of REQ-022 is active; undefined: DECODE always runs MAX_CYCLES cycles, converged stays 0, and the zero-run counter is not synthesised.

Structure
REQ-031 Package fptd_pkg holds the FSM state enum, FRAME_LEN and MAX_CYCLES defaults, and count-width constants, shared with Section-level tops.
REQ-032 One sub-module fptd_popcount (combinational FRAME_LEN-bit adder tree) is instantiated; the FSM and counters live in fptd_iter_ctrl.

Verification
REQ-033 Reset, then start at t0 with b1_error_bus all ones -> nClear=0 for one cycle, Enable=1 for 101 cycles (1 CLEAR + 100 DECODE), done pulse, cycle_count=100, converged=0, err_count=104.
REQ-034 FPTD_EARLY_TERM_EN defined; errors 5,3,0,0 on decode cycles 1-4 -> done after cycle 5 (one-cycle err latency plus ET_WIN=2), converged=1, cycle_count=5.
REQ-035 Same stimulus with macro undefined -> runs full 100 cycles, converged=0.
REQ-036 abort on decode cycle 10 -> Enable=0 next cycle, no done pulse, busy=0; a new start -> nClear=0 again.
REQ-037 start pulsed during DECODE and during DONE -> no restart; start and abort together in IDLE -> stays IDLE.
REQ-038 nReset asserted mid-decode between clock edges -> Enable=0 and nClear=1 immediately, all counters 0.

Source files
------------

// File: rtl/fptd_pkg.sv
// -----------------------------------------------------------------------------
// fptd_pkg
// Shared constants and types for the fully-parallel turbo decoder iteration
// controller and the Section-level tops that sit next to it.
//   FPTD_FRAME_LEN  : number of trellis Sections driven in parallel
//   FPTD_MAX_CYCLES : maximum decoding cycles per frame
//   FPTD_ET_WIN     : consecutive zero-error cycles needed to terminate early
//   FPTD_ERR_W      : width of a popcount over FPTD_FRAME_LEN error flags
//   FPTD_CYC_W      : width of a decoding-cycle counter up to FPTD_MAX_CYCLES
//   fptd_state_t    : iteration controller FSM state
// -----------------------------------------------------------------------------
package fptd_pkg;

    localparam int FPTD_FRAME_LEN  = 104;
    localparam int FPTD_MAX_CYCLES = 100;
    localparam int FPTD_ET_WIN     = 2;

    localparam int FPTD_ERR_W = $clog2(FPTD_FRAME_LEN + 1);
    localparam int FPTD_CYC_W = $clog2(FPTD_MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_DECODE = 2'd2,
        ST_DONE   = 2'd3
    } fptd_state_t;

    // Width of a counter that must hold every value from 0 to max_val.
    function automatic int fptd_cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fptd_popcount.sv
// -----------------------------------------------------------------------------
// fptd_popcount
// Combinational population count of an N-bit vector, built as a balanced
// binary adder tree. The input is zero-padded to the next power of two so the
// tree is regular; padding leaves are constant zero and fold away.
// Ports:
//   bits  [N-1:0]  : input flags
//   count [CW-1:0] : number of set bits (CW is wide enough for N, no overflow)
// -----------------------------------------------------------------------------
module fptd_popcount
    import fptd_pkg::*;
#(
    parameter int N  = FPTD_FRAME_LEN,
    parameter int CW = fptd_cnt_w(N)
) (
    input  logic [N-1:0]  bits,
    output logic [CW-1:0] count
);

    localparam int LV    = (N > 1) ? $clog2(N) : 1;
    localparam int N_PAD = 1 << LV;

    // Each tree level is its own array so no level feeds back into itself.
    for (genvar l = 0; l <= LV; l++) begin : g_lvl
        localparam int NODES = N_PAD >> l;
        logic [CW-1:0] s [NODES];

        for (genvar i = 0; i < NODES; i++) begin : g_node
            if (l == 0) begin : g_leaf
                if (i < N) begin : g_bit
                    assign s[i] = CW'(bits[i]);
                end else begin : g_pad
                    assign s[i] = '0;
                end
            end else begin : g_add
                assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
            end
        end
    end

    assign count = g_lvl[LV].s[0];

endmodule

// File: rtl/fptd_iter_ctrl.sv
// -----------------------------------------------------------------------------
// fptd_iter_ctrl
// Iteration controller for a fully-parallel turbo decoder. Broadcasts Enable
// and a one-cycle metric clear to every Section, counts decoding cycles, and
// watches the per-Section b1_error flags to end the frame.
//
// Build option:
//   FPTD_EARLY_TERM_EN  defined   -> frame ends after ET_WIN consecutive
//                                    decode cycles with err_count == 0
//                       undefined -> every frame runs MAX_CYCLES cycles;
//                                    converged stays 0 and no zero-run
//                                    counter exists
//
// Ports:
//   Clock        : clock, rising edge
//   nReset       : asynchronous active-low reset
//   start        : one-cycle request to decode the loaded frame (IDLE only)
//   abort        : cancel current decode (CLEAR/DECODE); beats start in IDLE
//   b1_error_bus : b1_error flag of every Section, bit i from Section i
//   Enable       : Section enable broadcast
//   nClear       : active-low alpha/beta metric clear broadcast
//   busy         : high from CLEAR through DECODE
//   done         : one-cycle pulse at frame completion
//   converged    : frame ended by early termination, held until next start
//   cycle_count  : decoding cycles used, held until next start
//   err_count    : registered popcount of b1_error_bus, updated in DECODE
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; Sections disabled
// CLEAR  | one cycle, Sections enabled with metrics cleared
// DECODE | Sections iterate; cycle and error counters run
// DONE   | one cycle, done pulse; back to IDLE
// -----------------------------------------------------------------------------
module fptd_iter_ctrl
    import fptd_pkg::*;
#(
    parameter int FRAME_LEN  = FPTD_FRAME_LEN,
    parameter int MAX_CYCLES = FPTD_MAX_CYCLES,
    parameter int ET_WIN     = FPTD_ET_WIN
) (
    input  logic                                Clock,
    input  logic                                nReset,
    input  logic                                start,
    input  logic                                abort,
    input  logic [FRAME_LEN-1:0]                b1_error_bus,
    output logic                                Enable,
    output logic                                nClear,
    output logic                                busy,
    output logic                                done,
    output logic                                converged,
    output logic [$clog2(MAX_CYCLES+1)-1:0]     cycle_count,
    output logic [$clog2(FRAME_LEN+1)-1:0]      err_count
);

    localparam int CYC_W = fptd_cnt_w(MAX_CYCLES);
    localparam int ERR_W = fptd_cnt_w(FRAME_LEN);
    localparam logic [CYC_W-1:0] CYC_MAX = CYC_W'(MAX_CYCLES);

    fptd_state_t      state;
    logic [ERR_W-1:0] pop_now;
    logic [CYC_W-1:0] cyc_inc;
    logic             cyc_last;
    logic             et_hit;
    logic             start_ok;

    fptd_popcount #(
        .N  (FRAME_LEN),
        .CW (ERR_W)
    ) u_popcount (
        .bits  (b1_error_bus),
        .count (pop_now)
    );

    assign start_ok = (state == ST_IDLE) && start && !abort;
    assign cyc_inc  = (cycle_count == CYC_MAX) ? cycle_count : cycle_count + CYC_W'(1);
    assign cyc_last = (cyc_inc == CYC_MAX);

`ifdef FPTD_EARLY_TERM_EN
    localparam int ZR_W = fptd_cnt_w(ET_WIN);
    localparam logic [ZR_W-1:0] ZR_WIN = ZR_W'(ET_WIN);

    logic [ZR_W-1:0] zero_run;
    logic [ZR_W-1:0] zero_run_nxt;

    // err_count seen in this DECODE cycle is the popcount of the previous
    // cycle, so the exit lags the last error by one cycle plus the window.
    assign zero_run_nxt = (err_count == '0) ? zero_run + ZR_W'(1) : '0;
    assign et_hit       = (zero_run_nxt == ZR_WIN);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            zero_run <= '0;
        end else if (start_ok) begin
            zero_run <= '0;
        end else if (state == ST_DECODE) begin
            zero_run <= zero_run_nxt;
        end
    end
`else
    assign et_hit = 1'b0;

    // ET_WIN has no effect in this build; kept so both builds share one
    // parameter list.
    if (ET_WIN < 1) begin : g_et_win_unused
    end
`endif

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state       <= ST_IDLE;
            Enable      <= 1'b0;
            nClear      <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            converged   <= 1'b0;
            cycle_count <= '0;
            err_count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state       <= ST_CLEAR;
                        Enable      <= 1'b1;
                        nClear      <= 1'b0;
                        busy        <= 1'b1;
                        cycle_count <= '0;
                        converged   <= 1'b0;
                    end
                end

                ST_CLEAR: begin
                    nClear <= 1'b1;
                    if (abort) begin
                        state     <= ST_IDLE;
                        Enable    <= 1'b0;
                        busy      <= 1'b0;
                        converged <= 1'b0;
                    end else begin
                        state <= ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    cycle_count <= cyc_inc;
                    err_count   <= pop_now;
                    if (abort) begin
                        state     <= ST_IDLE;
                        Enable    <= 1'b0;
                        busy      <= 1'b0;
                        converged <= 1'b0;
                    end else if (et_hit || cyc_last) begin
                        // Early termination wins the label when both end
                        // conditions land on the same cycle.
                        state     <= ST_DONE;
                        Enable    <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        converged <= et_hit;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state  <= ST_IDLE;
                    Enable <= 1'b0;
                    nClear <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
